// File: rtl/srst_sequencer.sv
// -----------------------------------------------------------------------------
// srst_sequencer
// Arbitrates soft-reset requests from NREQ sources in the CSR clock domain,
// issues a single rstsoft pulse to the reset controller, then follows the
// synchronized domain reset-status lines through reset entry and exit before
// signalling completion (done) or a timeout (err_tmo).
// Only one sequence runs at a time.
//
// All outputs are registered, so each one is a one-cycle-delayed view of the
// internal FSM. For example, rstsoft appears two cycles after a request
// arrives in IDLE.
//
// Parameters
//   NREQ          number of requesters (2..8)
//   TMO_CYCLES    cycles allowed in each WAIT state before timeout
//   GUARD_CYCLES  settle cycles after both domains leave reset
//
// Ports
//   clkcsr      in   CSR clock, the only clock
//   rstcsr      in   synchronous active-high reset
//   req         in   [NREQ] level request per source
//   rrstn_sync  in   receive-domain reset status (0 = in reset)
//   hrstn_sync  in   DMA-domain reset status (0 = in reset)
//   clr_err     in   clears err_sticky
//   rstsoft     out  1-cycle soft-reset pulse
//   grant       out  [NREQ] one-hot source being serviced, 0 when idle
//   busy        out  high while a sequence is in progress
//   done        out  1-cycle end-of-sequence pulse
//   err_tmo     out  1-cycle timeout pulse, coincident with done
//   err_sticky  out  set by err_tmo, cleared by clr_err or rstcsr
//
// Optional feature (macro SRST_CAUSE_LOG_EN)
//   last_cause  out  [NREQ] grant of the most recently completed sequence
//   seq_count   out  [8] saturating count of completed sequences
// -----------------------------------------------------------------------------
module srst_sequencer #(
    parameter int NREQ         = 4,
    parameter int TMO_CYCLES   = 255,
    parameter int GUARD_CYCLES = 4
) (
    input  logic            clkcsr,
    input  logic            rstcsr,
    input  logic [NREQ-1:0] req,
    input  logic            rrstn_sync,
    input  logic            hrstn_sync,
    input  logic            clr_err,
    output logic            rstsoft,
    output logic [NREQ-1:0] grant,
    output logic            busy,
    output logic            done,
    output logic            err_tmo,
    output logic            err_sticky
`ifdef SRST_CAUSE_LOG_EN
    ,
    output logic [NREQ-1:0] last_cause,
    output logic [7:0]      seq_count
`endif
);

    localparam int CNT_MAX = (TMO_CYCLES > GUARD_CYCLES) ? TMO_CYCLES : GUARD_CYCLES;
    localparam int TW      = $clog2(CNT_MAX + 1);
    localparam int PW      = $clog2(NREQ);

    localparam logic [TW-1:0] TMO_LAST   = TW'(TMO_CYCLES - 1);
    localparam logic [TW-1:0] GUARD_LAST = TW'(GUARD_CYCLES - 1);
    localparam logic [PW-1:0] PTR_LAST   = PW'(NREQ - 1);
    localparam logic [PW:0]   NREQ_W     = (PW+1)'(NREQ);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ASSERT    = 3'd1,
        ST_WAIT_LOW  = 3'd2,
        ST_WAIT_HIGH = 3'd3,
        ST_GUARD     = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [NREQ-1:0] pending_r;
    logic [NREQ-1:0] pending_s;
    logic [NREQ-1:0] merged_s;
    logic [NREQ-1:0] absorb_s;
    logic [NREQ-1:0] pick_oh_s;
    logic [NREQ-1:0] sel_r;
    logic [PW-1:0]   rr_ptr_r;
    logic [PW-1:0]   pick_idx_s;
    logic [PW-1:0]   cand_s;
    logic [PW:0]     sum_s;
    logic            pick_vld_s;
    logic            grant_now_s;
    logic [TW-1:0]   timer_r;
    logic            timer_clr_s;
    logic            timer_inc_s;
    logic            tmo_hit_s;
    logic            tmo_r;
    logic            lines_low_s;
    logic            lines_high_s;

    assign lines_low_s  = ~rrstn_sync & ~hrstn_sync;
    assign lines_high_s = rrstn_sync & hrstn_sync;
    assign pick_oh_s    = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx_s;
    assign grant_now_s  = (state_r == ST_IDLE) && pick_vld_s;

    // Request merge: repeat requests from the source being serviced are absorbed
    always_comb begin
        absorb_s = '0;
        if (state_r != ST_IDLE) begin
            absorb_s = sel_r;
        end else begin
            absorb_s = '0;
        end
        merged_s = pending_r | (req & ~absorb_s);
        if (grant_now_s) begin
            pending_s = merged_s & ~pick_oh_s;
        end else begin
            pending_s = merged_s;
        end
    end

    // Round-robin search starting at rr_ptr_r, wrapping at NREQ
    always_comb begin
        pick_vld_s = 1'b0;
        pick_idx_s = '0;
        sum_s      = '0;
        cand_s     = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum_s = {1'b0, rr_ptr_r} + (PW+1)'(k);
            if (sum_s >= NREQ_W) begin
                sum_s = sum_s - NREQ_W;
            end else begin
                sum_s = sum_s;
            end
            cand_s = sum_s[PW-1:0];
            if (!pick_vld_s && merged_s[cand_s]) begin
                pick_vld_s = 1'b1;
                pick_idx_s = cand_s;
            end else begin
                pick_vld_s = pick_vld_s;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clkcsr) begin
        if (rstcsr) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state and timer control; an exit condition beats a same-cycle timeout
    always_comb begin
        state_s     = state_r;
        timer_clr_s = 1'b0;
        timer_inc_s = 1'b0;
        tmo_hit_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_vld_s) begin
                    state_s = ST_ASSERT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ASSERT: begin
                state_s     = ST_WAIT_LOW;
                timer_clr_s = 1'b1;
            end
            ST_WAIT_LOW: begin
                if (lines_low_s) begin
                    state_s     = ST_WAIT_HIGH;
                    timer_clr_s = 1'b1;
                end else if (timer_r == TMO_LAST) begin
                    state_s   = ST_DONE;
                    tmo_hit_s = 1'b1;
                end else begin
                    timer_inc_s = 1'b1;
                end
            end
            ST_WAIT_HIGH: begin
                if (lines_high_s) begin
                    state_s     = ST_GUARD;
                    timer_clr_s = 1'b1;
                end else if (timer_r == TMO_LAST) begin
                    state_s   = ST_DONE;
                    tmo_hit_s = 1'b1;
                end else begin
                    timer_inc_s = 1'b1;
                end
            end
            ST_GUARD: begin
                if (timer_r == GUARD_LAST) begin
                    state_s = ST_DONE;
                end else begin
                    timer_inc_s = 1'b1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Wait/guard timer; increments only below its terminal value, so it never wraps
    always_ff @(posedge clkcsr) begin
        if (rstcsr) begin
            timer_r <= '0;
        end else if (timer_clr_s) begin
            timer_r <= '0;
        end else if (timer_inc_s) begin
            timer_r <= timer_r + TW'(1);
        end else begin
            timer_r <= timer_r;
        end
    end

    // Remembers that the current sequence ended by timeout
    always_ff @(posedge clkcsr) begin
        if (rstcsr) begin
            tmo_r <= 1'b0;
        end else if (tmo_hit_s) begin
            tmo_r <= 1'b1;
        end else if (state_r == ST_DONE) begin
            tmo_r <= 1'b0;
        end else begin
            tmo_r <= tmo_r;
        end
    end

    // Pending requests, serviced source and round-robin pointer
    always_ff @(posedge clkcsr) begin
        if (rstcsr) begin
            pending_r <= '0;
            sel_r     <= '0;
            rr_ptr_r  <= '0;
        end else begin
            pending_r <= pending_s;
            if (grant_now_s) begin
                sel_r    <= pick_oh_s;
                rr_ptr_r <= (pick_idx_s == PTR_LAST) ? '0 : pick_idx_s + PW'(1);
            end else if (state_r == ST_DONE) begin
                sel_r    <= '0;
                rr_ptr_r <= rr_ptr_r;
            end else begin
                sel_r    <= sel_r;
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    // Registered outputs; err_sticky is set by the err_tmo pulse and set wins over clr_err
    always_ff @(posedge clkcsr) begin
        if (rstcsr) begin
            rstsoft    <= 1'b0;
            grant      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_tmo    <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            rstsoft    <= (state_r == ST_ASSERT);
            grant      <= sel_r;
            busy       <= (state_r != ST_IDLE);
            done       <= (state_r == ST_DONE);
            err_tmo    <= (state_r == ST_DONE) && tmo_r;
            err_sticky <= err_tmo | (err_sticky & ~clr_err);
        end
    end

`ifdef SRST_CAUSE_LOG_EN
    // Cause log: last serviced source and saturating completion count
    always_ff @(posedge clkcsr) begin
        if (rstcsr) begin
            last_cause <= '0;
            seq_count  <= 8'd0;
        end else if (state_r == ST_DONE) begin
            last_cause <= sel_r;
            seq_count  <= (seq_count == 8'hFF) ? seq_count : seq_count + 8'd1;
        end else begin
            last_cause <= last_cause;
            seq_count  <= seq_count;
        end
    end
`endif

endmodule
